// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon 32/64 key schedule.
// The z0 sequence is stored so that z0[0] (leftmost in the published string) is the MSB.
package simon_pkg;

  localparam int WORD_W     = 16;
  localparam int KEY_WORDS  = 4;
  localparam int NUM_ROUNDS = 32;

  localparam logic [61:0] Z0      = 62'b11111010001001010110000111001101111101000100101011000011100110;
  localparam logic [15:0] C_CONST = 16'hFFFC;

  typedef logic [WORD_W-1:0] word_t;
  typedef word_t [NUM_ROUNDS-1:0] round_keys_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  function automatic word_t ror16(input word_t x, input logic [3:0] n);
    word_t r;
    r = (x >> n) | (x << (5'd16 - {1'b0, n}));
    return r;
  endfunction

  // Sequence bit for round i, wrapping every 62 rounds.
  function automatic logic z0_bit(input logic [6:0] i);
    logic [6:0] m;
    logic [5:0] pos;
    m   = i % 7'd62;
    pos = 6'd61 - m[5:0];
    return Z0[pos];
  endfunction

endpackage

// File: rtl/simon_key_round_f.sv
// Combinational Simon 32/64 next-round-key function:
// k[i+4] = C ^ z ^ k[i] ^ t ^ ror(t,1), with t = ror(k[i+3],3) ^ k[i+1].
module simon_key_round_f
  import simon_pkg::*;
(
  input  word_t k_i,
  input  word_t k_i1,
  input  word_t k_i3,
  input  logic  z_bit,
  output word_t k_i4
);

  word_t t_s;

  // Next key from the sliding four-word window.
  always_comb begin
    t_s  = ror16(k_i3, 4'd3) ^ k_i1;
    k_i4 = C_CONST ^ {15'd0, z_bit} ^ k_i ^ t_s ^ ror16(t_s, 4'd1);
  end

endmodule

// File: rtl/simon_key_expand_seq.sv
// Iterative Simon 32/64 key expansion: one round key per clock into a packed table.
// Optional macro SIMON_KEYEXP_STREAM_EN adds a per-key stream port (rk_out/rk_idx/rk_valid).
module simon_key_expand_seq
  import simon_pkg::*;
#(
  parameter int ROUNDS = NUM_ROUNDS,
  parameter int WORD   = WORD_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [63:0]                  key_in,
  input  logic                         key_valid,
  output logic                         key_ready,
  output logic [ROUNDS-1:0][WORD-1:0]  key,
  output logic                         keys_valid,
  output logic                         busy
`ifdef SIMON_KEYEXP_STREAM_EN
  ,
  output logic [15:0]                  rk_out,
  output logic [4:0]                   rk_idx,
  output logic                         rk_valid
`endif
);

  localparam int IDX_W = $clog2(ROUNDS);
  localparam logic [IDX_W-1:0] LAST_CNT = IDX_W'(ROUNDS - 5);

  if (WORD != WORD_W) begin : g_word_chk
    $error("simon_key_expand_seq: WORD must be 16");
  end
  if ((ROUNDS < 5) || (ROUNDS > 66)) begin : g_rounds_chk
    $error("simon_key_expand_seq: ROUNDS must be within 5..66");
  end

  state_e                      state_q, state_d;
  logic [ROUNDS-1:0][WORD-1:0] key_q, key_d;
  logic [IDX_W-1:0]            cnt_q, cnt_d;
  logic                        keys_valid_q, keys_valid_d;
  logic                        busy_q, busy_d;
  logic                        key_ready_q, key_ready_d;
`ifdef SIMON_KEYEXP_STREAM_EN
  logic [15:0]                 rk_out_q, rk_out_d;
  logic [4:0]                  rk_idx_q, rk_idx_d;
  logic                        rk_valid_q, rk_valid_d;
`endif

  logic [IDX_W-1:0] idx_p1_s, idx_p3_s, wr_idx_s;
  logic             z_bit_s;
  logic             accept_s;
  word_t            next_key_s;

  assign idx_p1_s = cnt_q + IDX_W'(1);
  assign idx_p3_s = cnt_q + IDX_W'(3);
  assign wr_idx_s = cnt_q + IDX_W'(4);
  assign z_bit_s  = z0_bit(7'(cnt_q));
  assign accept_s = key_valid & key_ready_q;

  simon_key_round_f u_round (
    .k_i   (key_q[cnt_q]),
    .k_i1  (key_q[idx_p1_s]),
    .k_i3  (key_q[idx_p3_s]),
    .z_bit (z_bit_s),
    .k_i4  (next_key_s)
  );

  // Next-state and next-output computation for the whole block.
  always_comb begin
    state_d      = state_q;
    key_d        = key_q;
    cnt_d        = cnt_q;
    keys_valid_d = keys_valid_q;
    busy_d       = busy_q;
    key_ready_d  = key_ready_q;
`ifdef SIMON_KEYEXP_STREAM_EN
    rk_out_d     = rk_out_q;
    rk_idx_d     = rk_idx_q;
    rk_valid_d   = 1'b0;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        key_ready_d = 1'b1;
        busy_d      = 1'b0;
        if (accept_s) begin
          key_d[0]     = key_in[15:0];
          key_d[1]     = key_in[31:16];
          key_d[2]     = key_in[47:32];
          key_d[3]     = key_in[63:48];
          cnt_d        = '0;
          keys_valid_d = 1'b0;
          busy_d       = 1'b1;
          key_ready_d  = 1'b0;
          state_d      = ST_EXPAND;
        end else begin
          state_d = state_q;
        end
      end
      ST_EXPAND: begin
        key_d[wr_idx_s] = next_key_s;
        cnt_d           = cnt_q + IDX_W'(1);
`ifdef SIMON_KEYEXP_STREAM_EN
        rk_out_d        = next_key_s;
        rk_idx_d        = 5'(wr_idx_s);
        rk_valid_d      = 1'b1;
`endif
        if (cnt_q == LAST_CNT) begin
          state_d      = ST_DONE;
          keys_valid_d = 1'b1;
          busy_d       = 1'b0;
          key_ready_d  = 1'b1;
        end else begin
          state_d     = ST_EXPAND;
          busy_d      = 1'b1;
          key_ready_d = 1'b0;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        keys_valid_d = 1'b0;
        busy_d       = 1'b0;
        key_ready_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset wipes the whole table.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      key_q        <= '0;
      cnt_q        <= '0;
      keys_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      key_ready_q  <= 1'b0;
`ifdef SIMON_KEYEXP_STREAM_EN
      rk_out_q     <= 16'd0;
      rk_idx_q     <= 5'd0;
      rk_valid_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      key_q        <= key_d;
      cnt_q        <= cnt_d;
      keys_valid_q <= keys_valid_d;
      busy_q       <= busy_d;
      key_ready_q  <= key_ready_d;
`ifdef SIMON_KEYEXP_STREAM_EN
      rk_out_q     <= rk_out_d;
      rk_idx_q     <= rk_idx_d;
      rk_valid_q   <= rk_valid_d;
`endif
    end
  end

  assign key        = key_q;
  assign keys_valid = keys_valid_q;
  assign busy       = busy_q;
  assign key_ready  = key_ready_q;
`ifdef SIMON_KEYEXP_STREAM_EN
  assign rk_out     = rk_out_q;
  assign rk_idx     = rk_idx_q;
  assign rk_valid   = rk_valid_q;
`endif

endmodule

// File: tb/tb_simon_key_expand_seq.sv
// Scoreboard bench for simon_key_expand_seq: expected tables come from a software key schedule,
// a monitor pops them when keys_valid rises and checks contents and latency.
module tb_simon_key_expand_seq;

  localparam int R = 32;
  typedef logic [R-1:0][15:0] tbl_t;
  typedef struct {
    tbl_t tbl;
    int   acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] key_in;
  logic        key_valid;
  logic        key_ready;
  tbl_t        key;
  logic        keys_valid;
  logic        busy;
`ifdef SIMON_KEYEXP_STREAM_EN
  logic [15:0] rk_out;
  logic [4:0]  rk_idx;
  logic        rk_valid;
`endif

  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc      = 0;
  exp_t  exp_q[$];
  string z0s = "11111010001001010110000111001101111101000100101011000011100110";

  simon_key_expand_seq dut (
    .clk        (clk),
    .rst        (rst),
    .key_in     (key_in),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .key        (key),
    .keys_valid (keys_valid),
    .busy       (busy)
`ifdef SIMON_KEYEXP_STREAM_EN
    ,
    .rk_out     (rk_out),
    .rk_idx     (rk_idx),
    .rk_valid   (rk_valid)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int unsigned rotr(input int unsigned x, input int n);
    return ((x >> n) | (x << (16 - n))) & 32'hFFFF;
  endfunction

  function automatic int unsigned zbit(input int i);
    return (z0s[i] == "1") ? 1 : 0;
  endfunction

  // Reference key schedule written straight from the round-key recurrence.
  function automatic tbl_t model(input logic [63:0] k);
    int unsigned w[R];
    int unsigned t;
    tbl_t r;
    for (int i = 0; i < 4; i++) w[i] = {16'd0, k[16*i +: 16]};
    for (int i = 0; i < R - 4; i++) begin
      t = rotr(w[i+3], 3) ^ w[i+1];
      w[i+4] = 32'hFFFC ^ zbit(i % 62) ^ w[i] ^ t ^ rotr(t, 1);
    end
    for (int i = 0; i < R; i++) r[i] = w[i][15:0];
    return r;
  endfunction

  function automatic logic [15:0] rol(input logic [15:0] x, input int n);
    return (x << n) | (x >> (16 - n));
  endfunction

  function automatic logic [31:0] encrypt(input tbl_t rk, input logic [31:0] pt);
    logic [15:0] x, y, t;
    x = pt[31:16];
    y = pt[15:0];
    for (int i = 0; i < R; i++) begin
      t = x;
      x = y ^ (rol(x, 1) & rol(x, 8)) ^ rol(x, 2) ^ rk[i];
      y = t;
    end
    return {x, y};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic check_tbl(input string name, input tbl_t act, input tbl_t expv);
    int bad;
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      bad = 0;
      for (int i = R - 1; i >= 0; i--) if (act[i] !== expv[i]) bad = i;
      $display("FAIL %s: key[%0d] got %h expected %h", name, bad, act[bad], expv[bad]);
    end
  endtask

  // Drives key_in with valid until accepted; returns one negedge after the accept edge.
  task automatic accept_key(input logic [63:0] k);
    exp_t e;
    key_in    = k;
    key_valid = 1'b1;
    for (int i = 0; i < 60 && !key_ready; i++) @(negedge clk);
    if (!key_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: got key_ready=0 expected 1");
    end else begin
      e.tbl = model(k);
      e.acc = cyc + 1;
      exp_q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40 && !keys_valid; i++) @(negedge clk);
    check("keys_valid_timeout", {63'd0, keys_valid}, 64'd1);
  endtask

  // Monitor: compares each completed table (and stream pulses) against the scoreboard.
  logic kv_prev = 1'b0;
  int   pulse_n = 0;
  int   exp_idx = 4;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      kv_prev = 1'b0;
      pulse_n = 0;
      exp_idx = 4;
    end else begin
`ifdef SIMON_KEYEXP_STREAM_EN
      if (rk_valid) begin
        if (exp_q.size() == 0 || exp_idx >= R) begin
          n_checks++;
          n_fail++;
          $display("FAIL rk_unexpected: got rk_idx %0d expected no pulse", rk_idx);
        end else begin
          check("rk_idx", {59'd0, rk_idx}, exp_idx);
          check("rk_out", {48'd0, rk_out}, {48'd0, exp_q[0].tbl[exp_idx]});
        end
        exp_idx++;
        pulse_n++;
      end
`endif
      if (keys_valid && !kv_prev) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL keys_valid_unexpected: got rise expected none");
        end else begin
          e = exp_q.pop_front();
          check_tbl("table", key, e.tbl);
          check("latency", cyc - e.acc, R - 4);
`ifdef SIMON_KEYEXP_STREAM_EN
          check("rk_pulses", pulse_n, R - 4);
`endif
        end
        pulse_n = 0;
        exp_idx = 4;
      end
      kv_prev = keys_valid;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] ka, kb;
    tbl_t zt;
    rst       = 1'b1;
    key_valid = 1'b0;
    key_in    = 64'd0;
    @(negedge clk);
    check("rst_key_ready", {63'd0, key_ready}, 64'd0);
    check("rst_keys_valid", {63'd0, keys_valid}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check_tbl("rst_table", key, '0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_key_ready", {63'd0, key_ready}, 64'd1);

    // Standard vector
    accept_key(64'h1918_1110_0908_0100);
    check("exp_busy", {63'd0, busy}, 64'd1);
    check("exp_key_ready", {63'd0, key_ready}, 64'd0);
    key_valid = 1'b0;
    key_in    = 64'hDEAD_BEEF_CAFE_F00D;
    wait_done();
    check("std_k0_3", {key[3], key[2], key[1], key[0]}, 64'h1918_1110_0908_0100);
    check("std_k4", {48'd0, key[4]}, 64'h71C3);
    check("std_cipher", {32'd0, encrypt(key, 32'h6565_6877)}, 64'hC69B_E9BB);

    // All-zero key, then hold in DONE
    accept_key(64'd0);
    key_valid = 1'b0;
    wait_done();
    check("zero_k4", {48'd0, key[4]}, 64'hFFFD);
    repeat (5) @(negedge clk);
    zt = model(64'd0);
    check_tbl("done_hold", key, zt);
    check("done_kv", {63'd0, keys_valid}, 64'd1);
    check("done_ready", {63'd0, key_ready}, 64'd1);

    // Reset in the middle of an expansion
    accept_key({$urandom, $urandom});
    key_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_kv", {63'd0, keys_valid}, 64'd0);
    check("mid_rst_busy", {63'd0, busy}, 64'd0);
    check_tbl("mid_rst_table", key, '0);
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("mid_rst_ready", {63'd0, key_ready}, 64'd1);
    accept_key({$urandom, $urandom});
    key_valid = 1'b0;
    wait_done();

    // Back-pressure: a second key held valid during expansion is taken only in DONE
    ka = {$urandom, $urandom};
    kb = {$urandom, $urandom};
    accept_key(ka);
    accept_key(kb);
    check("bp_kv_drop", {63'd0, keys_valid}, 64'd0);
    check("bp_busy", {63'd0, busy}, 64'd1);
    key_valid = 1'b0;
    wait_done();

    // Random keys
    for (int n = 0; n < 6; n++) begin
      accept_key({$urandom, $urandom});
      key_valid = 1'b0;
      key_in    = {$urandom, $urandom};
      wait_done();
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
